// File: rtl/alu_pkg.sv
// Shared opcode encodings, internal operation selects and constants for the
// registered arithmetic unit.
package alu_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   typedef enum logic [1:0] {
      SEL_ADD,
      SEL_SUB,
      SEL_DIV,
      SEL_HOLD
   } op_select_t;

   localparam int unsigned DATA_W = 8;

   // Quotient reported when the divisor is zero.
   localparam logic [DATA_W-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/arith_divider.sv
// Combinational restoring array divider: one compare/subtract stage per
// quotient bit, MSB first. A zero divisor yields the all-ones quotient.
module arith_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             div_zero
);

   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] q_raw;

   always_comb begin
      rem   = '0;
      q_raw = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         rem = {rem[WIDTH-1:0], dividend[i]};
         if (rem >= {1'b0, divisor}) begin
            rem      = rem - {1'b0, divisor};
            q_raw[i] = 1'b1;
         end
      end
   end

   assign div_zero = (divisor == '0);
   assign quotient = div_zero ? WIDTH'(DIV0_RESULT) : q_raw;

endmodule

// File: rtl/arithmetic_unit.sv
// Registered 8-bit ADD/SUB/DIV datapath with opcode decode, a result-enable
// mux and registered result/carry/div_zero/zero flags (one cycle latency).
module arithmetic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       opcode,
   input  logic             result_en,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             div_zero,
   output logic             zero
);

   op_select_t       op_sel;
   logic [WIDTH:0]   sum_full;
   logic [WIDTH:0]   diff_full;
   logic [WIDTH-1:0] quotient;
   logic             div_by_zero;

   logic [WIDTH-1:0] result_d, result_q;
   logic             carry_d, carry_q;
   logic             div_zero_d, div_zero_q;
   logic             zero_d, zero_q;

   // Unknown or unlisted opcodes fall back to HOLD so state is never corrupted.
   always_comb begin
      case (opcode)
         OP_ADD:  op_sel = SEL_ADD;
         OP_SUB:  op_sel = SEL_SUB;
         OP_DIV:  op_sel = SEL_DIV;
         OP_HOLD: op_sel = SEL_HOLD;
         default: op_sel = SEL_HOLD;
      endcase
   end

   assign sum_full  = {1'b0, a} + {1'b0, b};
   assign diff_full = {1'b0, a} - {1'b0, b};

   arith_divider #(
      .WIDTH(WIDTH)
   ) u_divider (
      .dividend(a),
      .divisor (b),
      .quotient(quotient),
      .div_zero(div_by_zero)
   );

   // The top bit of the 9-bit difference is the borrow, i.e. a < b.
   always_comb begin
      result_d   = result_q;
      carry_d    = carry_q;
      div_zero_d = div_zero_q;
      if (!result_en) begin
         result_d   = '0;
         carry_d    = 1'b0;
         div_zero_d = 1'b0;
      end else begin
         case (op_sel)
            SEL_ADD: begin
               result_d   = sum_full[WIDTH-1:0];
               carry_d    = sum_full[WIDTH];
               div_zero_d = 1'b0;
            end
            SEL_SUB: begin
               result_d   = diff_full[WIDTH-1:0];
               carry_d    = diff_full[WIDTH];
               div_zero_d = 1'b0;
            end
            SEL_DIV: begin
               result_d   = quotient;
               carry_d    = 1'b0;
               div_zero_d = div_by_zero;
            end
            default: begin
               result_d   = result_q;
               carry_d    = carry_q;
               div_zero_d = div_zero_q;
            end
         endcase
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q   <= '0;
         carry_q    <= 1'b0;
         div_zero_q <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         result_q   <= result_d;
         carry_q    <= carry_d;
         div_zero_q <= div_zero_d;
         zero_q     <= zero_d;
      end
   end

   assign result   = result_q;
   assign carry    = carry_q;
   assign div_zero = div_zero_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_arithmetic_unit.sv
// Self-checking bench for arithmetic_unit: directed vectors, HOLD, result_en,
// asynchronous reset and randomized traffic against a behavioural model.
module tb_arithmetic_unit;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] opcode;
   logic       result_en;
   logic [7:0] result;
   logic       carry;
   logic       div_zero;
   logic       zero;

   int tests_run;
   int tests_failed;

   logic [7:0] exp_result;
   logic       exp_carry;
   logic       exp_dz;
   logic       exp_zero;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [7:0] res;
      logic       c;
      logic       dz;
   } vec_t;

   vec_t vecs[10];

   arithmetic_unit #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .opcode   (opcode),
      .result_en(result_en),
      .result   (result),
      .carry    (carry),
      .div_zero (div_zero),
      .zero     (zero)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive inputs away from the rising edge, then sample just after it.
   task automatic drive(input logic [7:0] av, input logic [7:0] bv,
                        input logic [1:0] op, input logic en);
      @(negedge clk);
      a         = av;
      b         = bv;
      opcode    = op;
      result_en = en;
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour written from the arithmetic rules with plain integers.
   task automatic model_step(input int av, input int bv, input int op, input logic en);
      int s;
      if (!en) begin
         exp_result = 8'd0;
         exp_carry  = 1'b0;
         exp_dz     = 1'b0;
      end else begin
         case (op)
            0: begin
               s          = av + bv;
               exp_result = 8'(s % 256);
               exp_carry  = (s > 255);
               exp_dz     = 1'b0;
            end
            1: begin
               exp_result = 8'((av - bv + 256) % 256);
               exp_carry  = (av < bv);
               exp_dz     = 1'b0;
            end
            2: begin
               if (bv == 0) begin
                  exp_result = 8'd255;
                  exp_dz     = 1'b1;
               end else begin
                  exp_result = 8'(av / bv);
                  exp_dz     = 1'b0;
               end
               exp_carry = 1'b0;
            end
            default: ;
         endcase
      end
      exp_zero = (exp_result == 8'd0);
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      a         = 8'd10;
      b         = 8'd5;
      opcode    = OP_ADD;
      result_en = 1'b1;
      #12;
      tests_run++;
      if (result !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_result: got %0d expected 0", result);
      end
      tests_run++;
      if (zero !== 1'b1 || carry !== 1'b0 || div_zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got zero=%0b carry=%0b dz=%0b expected 1 0 0",
                  zero, carry, div_zero);
      end
      #3;
      rst = 1'b1;
   endtask

   task automatic test_directed();
      vecs[0] = '{8'd10,  8'd5,  OP_ADD, 8'd15,  1'b0, 1'b0};
      vecs[1] = '{8'd20,  8'd10, OP_SUB, 8'd10,  1'b0, 1'b0};
      vecs[2] = '{8'd40,  8'd8,  OP_DIV, 8'd5,   1'b0, 1'b0};
      vecs[3] = '{8'd200, 8'd100, OP_ADD, 8'd44, 1'b1, 1'b0};
      vecs[4] = '{8'd5,   8'd10, OP_SUB, 8'd251, 1'b1, 1'b0};
      vecs[5] = '{8'd255, 8'd1,  OP_DIV, 8'd255, 1'b0, 1'b0};
      vecs[6] = '{8'd7,   8'd0,  OP_DIV, 8'd255, 1'b0, 1'b1};
      vecs[7] = '{8'd9,   8'd2,  OP_DIV, 8'd4,   1'b0, 1'b0};
      vecs[8] = '{8'd77,  8'd77, OP_SUB, 8'd0,   1'b0, 1'b0};
      vecs[9] = '{8'd255, 8'd1,  OP_ADD, 8'd0,   1'b1, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
         tests_run++;
         if (result !== vecs[i].res || carry !== vecs[i].c || div_zero !== vecs[i].dz ||
             zero !== (vecs[i].res == 8'd0)) begin
            tests_failed++;
            $display("[TB] FAIL directed_%0d: got res=%0d c=%0b dz=%0b z=%0b expected res=%0d c=%0b dz=%0b z=%0b",
                     i, result, carry, div_zero, zero, vecs[i].res, vecs[i].c, vecs[i].dz,
                     (vecs[i].res == 8'd0));
         end
      end
   endtask

   task automatic test_hold();
      drive(8'd10, 8'd5, OP_ADD, 1'b1);
      drive(8'd99, 8'd1, OP_HOLD, 1'b1);
      drive(8'd99, 8'd1, OP_HOLD, 1'b1);
      tests_run++;
      if (result !== 8'd15 || carry !== 1'b0 || zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hold_15: got res=%0d c=%0b z=%0b expected res=15 c=0 z=0",
                  result, carry, zero);
      end
      drive(8'd200, 8'd100, OP_ADD, 1'b1);
      drive(8'd0, 8'd0, OP_HOLD, 1'b1);
      tests_run++;
      if (result !== 8'd44 || carry !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_carry: got res=%0d c=%0b expected res=44 c=1", result, carry);
      end
      drive(8'd7, 8'd0, OP_DIV, 1'b1);
      drive(8'd3, 8'd3, OP_HOLD, 1'b1);
      tests_run++;
      if (result !== 8'd255 || div_zero !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_div_zero: got res=%0d dz=%0b expected res=255 dz=1",
                  result, div_zero);
      end
   endtask

   task automatic test_result_en();
      drive(8'd10, 8'd5, OP_ADD, 1'b1);
      drive(8'd10, 8'd5, OP_ADD, 1'b0);
      tests_run++;
      if (result !== 8'd0 || zero !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL en_off: got res=%0d z=%0b expected res=0 z=1", result, zero);
      end
      drive(8'd200, 8'd100, OP_ADD, 1'b1);
      drive(8'd1, 8'd1, OP_HOLD, 1'b0);
      tests_run++;
      if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL en_off_hold: got res=%0d c=%0b z=%0b expected res=0 c=0 z=1",
                  result, carry, zero);
      end
      drive(8'd7, 8'd0, OP_DIV, 1'b1);
      drive(8'd7, 8'd0, OP_DIV, 1'b0);
      tests_run++;
      if (div_zero !== 1'b0 || result !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL en_off_div0: got res=%0d dz=%0b expected res=0 dz=0",
                  result, div_zero);
      end
   endtask

   task automatic test_midstream_reset();
      drive(8'd10, 8'd5, OP_ADD, 1'b1);
      tests_run++;
      if (result !== 8'd15) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_load: got %0d expected 15", result);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (result !== 8'd0 || zero !== 1'b1 || carry !== 1'b0 || div_zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got res=%0d z=%0b c=%0b dz=%0b expected 0 1 0 0",
                  result, zero, carry, div_zero);
      end
      #1;
      rst = 1'b1;
      a   = 8'd3;
      b   = 8'd4;
      @(posedge clk);
      #1;
      tests_run++;
      if (result !== 8'd7 || zero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_load: got res=%0d z=%0b expected res=7 z=0", result, zero);
      end
   endtask

   task automatic test_random();
      int av, bv, op;
      logic en;
      drive(8'd0, 8'd0, OP_ADD, 1'b0);
      model_step(0, 0, 0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         av = int'($urandom_range(0, 255));
         bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         op = int'($urandom_range(0, 3));
         en = ($urandom_range(0, 7) != 0);
         drive(8'(av), 8'(bv), 2'(op), en);
         model_step(av, bv, op, en);
         tests_run++;
         if (result !== exp_result || carry !== exp_carry || div_zero !== exp_dz ||
             zero !== exp_zero) begin
            tests_failed++;
            $display("[TB] FAIL random_%0d a=%0d b=%0d op=%0d en=%0b: got res=%0d c=%0b dz=%0b z=%0b expected res=%0d c=%0b dz=%0b z=%0b",
                     i, av, bv, op, en, result, carry, div_zero, zero,
                     exp_result, exp_carry, exp_dz, exp_zero);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_directed();
      test_hold();
      test_result_en();
      test_midstream_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
